// File: rtl/ntt_pkg.sv
// Shared constants, state encoding and helpers for the NTT engines.
package ntt_pkg;
  localparam int N    = 256;
  localparam int LOGN = 8;
  localparam int Q    = 8380417;
  localparam int ZETA = 1753;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  function automatic logic [LOGN-1:0] bit_reverse(input logic [LOGN-1:0] x);
    logic [LOGN-1:0] r;
    r = '0;
    for (int i = 0; i < LOGN; i++) r[i] = x[LOGN-1-i];
    return r;
  endfunction

  // Elaboration-time modular power, used only to build constant tables.
  function automatic logic [31:0] pow_mod(input int unsigned base, input int unsigned e,
                                          input int unsigned m);
    logic [63:0] acc;
    acc = 64'd1;
    for (int unsigned i = 0; i < e; i++) acc = (acc * 64'(base)) % 64'(m);
    return acc[31:0];
  endfunction
endpackage

// File: rtl/fwd_twiddle_rom.sv
// Combinational forward twiddle ROM: entry j = ZETA^brv(j) mod Q (entry 0 unused).
module fwd_twiddle_rom #(
  parameter int N          = 256,
  parameter int WIDTH      = 32,
  parameter int Q          = 8380417,
  parameter int ADDR_WIDTH = 8
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0]      o_data
);
  import ntt_pkg::*;

  logic [WIDTH-1:0] w_tab [N];

  for (genvar j = 0; j < N; j++) begin : g_tab
    localparam logic [31:0] ENTRY = pow_mod(ZETA, 32'(bit_reverse(LOGN'(j))), Q);
    assign w_tab[j] = WIDTH'(ENTRY);
  end

  assign o_data = w_tab[i_addr];
endmodule

// File: rtl/mod_mult.sv
// Modular multiplier: o_p = i_a * i_b mod Q for operands below Q.
module mod_mult #(
  parameter int WIDTH          = 32,
  parameter int Q              = 8380417,
  parameter int REDUCTION_TYPE = 0
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_p
);
  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] w_prod;
  assign w_prod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

  if (REDUCTION_TYPE == 1) begin : g_barrett
    // Product is below 2^K, so one conditional subtraction fixes the quotient estimate.
    localparam int K = 2 * $clog2(Q);
    localparam logic [PW-1:0] M = PW'((128'd1 << K) / 128'(Q));
    logic [PW-1:0] w_qe;
    logic [PW-1:0] w_r;
    assign w_qe = PW'(({{PW{1'b0}}, w_prod} * {{PW{1'b0}}, M}) >> K);
    assign w_r  = w_prod - w_qe * PW'(Q);
    assign o_p  = (w_r >= PW'(Q)) ? WIDTH'(w_r - PW'(Q)) : WIDTH'(w_r);
  end else begin : g_simple
    // Montgomery form would need pre-scaled twiddles; it shares the exact-remainder path.
    assign o_p = WIDTH'(w_prod % PW'(Q));
  end
endmodule

// File: rtl/ntt_butterfly_forward.sv
// Cooley-Tukey butterfly: t = zeta*B, A' = A+t mod Q, B' = A-t mod Q.
module ntt_butterfly_forward #(
  parameter int WIDTH          = 32,
  parameter int Q              = 8380417,
  parameter int REDUCTION_TYPE = 0
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_zeta,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b
);
  logic [WIDTH-1:0] w_t;
  logic [WIDTH:0]   w_sum;

  mod_mult #(.WIDTH(WIDTH), .Q(Q), .REDUCTION_TYPE(REDUCTION_TYPE)) u_mul (
    .i_a(i_zeta), .i_b(i_b), .o_p(w_t)
  );

  assign w_sum = {1'b0, i_a} + {1'b0, w_t};
  assign o_a   = (w_sum >= (WIDTH+1)'(Q)) ? WIDTH'(w_sum - (WIDTH+1)'(Q)) : w_sum[WIDTH-1:0];
  assign o_b   = (i_a < w_t) ? (i_a + WIDTH'(Q) - w_t) : (i_a - w_t);
endmodule

// File: rtl/ntt_forward.sv
// Forward negacyclic NTT, in place, PARALLEL butterflies per cycle, bit-reversed output.
// Optional NTT_FWD_LOAD_REDUCE_EN reduces load_data mod Q before it is stored.
module ntt_forward #(
  parameter int N              = ntt_pkg::N,
  parameter int WIDTH          = 32,
  parameter int Q              = ntt_pkg::Q,
  parameter int ADDR_WIDTH     = 8,
  parameter int REDUCTION_TYPE = 0,
  parameter int PARALLEL       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  done,
  output logic                  busy,
  input  logic                  load_coeff,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [WIDTH-1:0]      load_data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [WIDTH-1:0]      read_data,
  output logic [1:0]            o_dbg_state
);
  import ntt_pkg::*;

  localparam int SW = $clog2(ADDR_WIDTH);
  localparam int KW = ADDR_WIDTH - 1;
  localparam logic [KW-1:0] K_LAST = KW'(N/2 - PARALLEL);
  localparam logic [SW-1:0] S_LAST = SW'(ADDR_WIDTH - 1);

  state_t                r_state;
  logic [SW-1:0]         r_stage;
  logic [KW-1:0]         r_base;
  logic [WIDTH-1:0]      r_mem [N];
  logic [WIDTH-1:0]      r_read_data;

  logic [ADDR_WIDTH-1:0] w_len;
  logic [ADDR_WIDTH-1:0] w_b      [PARALLEL];
  logic [ADDR_WIDTH-1:0] w_grp    [PARALLEL];
  logic [ADDR_WIDTH-1:0] w_addr0  [PARALLEL];
  logic [ADDR_WIDTH-1:0] w_addr1  [PARALLEL];
  logic [ADDR_WIDTH-1:0] w_tw_idx [PARALLEL];
  logic [WIDTH-1:0]      w_zeta   [PARALLEL];
  logic [WIDTH-1:0]      w_a_new  [PARALLEL];
  logic [WIDTH-1:0]      w_b_new  [PARALLEL];
  logic [WIDTH-1:0]      w_load_val;

`ifdef NTT_FWD_LOAD_REDUCE_EN
  assign w_load_val = load_data % WIDTH'(Q);
`else
  assign w_load_val = load_data;
`endif

  // Half-span shrinks from N/2 to 1 as the stage advances.
  assign w_len = ADDR_WIDTH'((N/2) >> r_stage);

  for (genvar i = 0; i < PARALLEL; i++) begin : g_lane
    assign w_b[i]      = ADDR_WIDTH'(r_base) + ADDR_WIDTH'(i);
    assign w_grp[i]    = w_b[i] >> (S_LAST - r_stage);
    assign w_addr0[i]  = ((w_grp[i] * w_len) << 1) + (w_b[i] & (w_len - 1'b1));
    assign w_addr1[i]  = w_addr0[i] + w_len;
    assign w_tw_idx[i] = (ADDR_WIDTH'(1) << r_stage) + w_grp[i];

    fwd_twiddle_rom #(.N(N), .WIDTH(WIDTH), .Q(Q), .ADDR_WIDTH(ADDR_WIDTH)) u_rom (
      .i_addr(w_tw_idx[i]), .o_data(w_zeta[i])
    );

    ntt_butterfly_forward #(.WIDTH(WIDTH), .Q(Q), .REDUCTION_TYPE(REDUCTION_TYPE)) u_bf (
      .i_a(r_mem[w_addr0[i]]), .i_b(r_mem[w_addr1[i]]), .i_zeta(w_zeta[i]),
      .o_a(w_a_new[i]), .o_b(w_b_new[i])
    );
  end

  // start/done handshake: start is taken only in IDLE; done holds until start is seen low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_stage <= '0;
      r_base  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_COMPUTE;
          r_stage <= '0;
          r_base  <= '0;
        end
        S_COMPUTE: if (r_base == K_LAST) begin
          r_base <= '0;
          if (r_stage == S_LAST) begin
            r_state <= S_DONE;
            r_stage <= '0;
          end else begin
            r_stage <= r_stage + 1'b1;
          end
        end else begin
          r_base <= r_base + KW'(PARALLEL);
        end
        S_DONE: if (!start) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && load_coeff) begin
      r_mem[load_addr] <= w_load_val;
    end else if (r_state == S_COMPUTE) begin
      for (int i = 0; i < PARALLEL; i++) begin
        r_mem[w_addr0[i]] <= w_a_new[i];
        r_mem[w_addr1[i]] <= w_b_new[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_read_data <= '0;
    else        r_read_data <= r_mem[read_addr];
  end

  assign read_data   = r_read_data;
  assign busy        = (r_state == S_COMPUTE);
  assign done        = (r_state == S_DONE);
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_ntt_forward.sv
// Self-checking bench for ntt_forward against a textbook Dilithium-style forward NTT.
module tb_ntt_forward;
  localparam int    N  = 256;
  localparam longint QL = 8380417;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        done, busy;
  logic        load_coeff = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic [7:0]  read_addr = '0;
  logic [31:0] read_data;
  logic [1:0]  dbg_state;

  ntt_forward dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .busy(busy),
    .load_coeff(load_coeff), .load_addr(load_addr), .load_data(load_data),
    .read_addr(read_addr), .read_data(read_data), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] tb_x [N];
  logic [31:0] tb_y [N];
  longint      tb_zeta [N];
  logic [31:0] exp_q [$];
  longint      due_q [$];

  longint m_c = -1;      // cycle in which start was driven for the current run
  longint m_end_c = -1;  // start cycle of the run the monitor has retired
  bit     m_en = 0;
  bit     m_done_prev = 0, m_start_prev = 0, m_rst_prev = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // reference model
  function automatic void build_zetas();
    for (int j = 0; j < N; j++) begin
      int r;
      longint p;
      r = 0;
      for (int bb = 0; bb < 8; bb++) if (j[bb]) r = r | (1 << (7 - bb));
      p = 1;
      for (int e = 0; e < r; e++) p = (p * 1753) % QL;
      tb_zeta[j] = p;
    end
  endfunction

  function automatic void ref_ntt();
    longint a [N];
    longint t;
    int k;
    k = 0;
    for (int i = 0; i < N; i++) a[i] = longint'(tb_x[i]);
    for (int len = 128; len > 0; len = len / 2) begin
      for (int st = 0; st < N; st += 2 * len) begin
        k++;
        for (int j = st; j < st + len; j++) begin
          t = (tb_zeta[k] * a[j + len]) % QL;
          a[j + len] = (a[j] - t + QL) % QL;
          a[j] = (a[j] + t) % QL;
        end
      end
    end
    for (int i = 0; i < N; i++) tb_y[i] = 32'(a[i]);
  endfunction

  // compare process: busy/done every cycle, read results when due
  always @(negedge clk) begin
    if (m_en) begin
      bit run, eb, ed;
      run = (m_c >= 0) && (m_c != m_end_c) && m_rst_prev;
      if (!m_rst_prev) m_end_c = m_c;
      eb = run && (cyc >= m_c + 1) && (cyc <= m_c + 128);
      if (run && cyc == m_c + 129)     ed = 1'b1;
      else if (run && cyc > m_c + 129) ed = m_done_prev && m_start_prev;
      else                             ed = 1'b0;
      if (run && cyc > m_c + 129 && !ed) m_end_c = m_c;
      check("busy", {63'd0, busy}, {63'd0, eb});
      check("done", {63'd0, done}, {63'd0, ed});
      m_done_prev  = ed;
      m_start_prev = start;
      m_rst_prev   = rst_n;
    end
    while (due_q.size() > 0 && due_q[0] == cyc) begin
      logic [31:0] e;
      void'(due_q.pop_front());
      e = exp_q.pop_front();
      check("read_data", {32'd0, read_data}, {32'd0, e});
    end
  end

  // driver tasks
  task automatic wait_cyc(input longint c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic load_and_start(input bit hold);
    for (int a = 0; a < N; a++) begin
      @(posedge clk); #1;
      load_coeff = 1'b1;
      load_addr  = 8'(a);
      load_data  = tb_x[a];
      if (a == N - 1) begin
        start = 1'b1;
        m_c = cyc;
      end
    end
    @(posedge clk); #1;
    load_coeff = 1'b0;
    if (!hold) start = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < N; a++) begin
      @(posedge clk); #1;
      read_addr = 8'(a);
      exp_q.push_back(tb_y[a]);
      due_q.push_back(cyc + 1);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_and_read(input bit hold, input bit poke);
    load_and_start(hold);
    if (poke) begin
      wait_cyc(m_c + 10);
      load_coeff = 1'b1; load_addr = 8'd3; load_data = 32'd77;
      wait_cyc(m_c + 11);
      load_coeff = 1'b0;
    end
    if (hold) begin
      wait_cyc(m_c + 140);
      start = 1'b0;
    end
    wait_cyc(m_c + 132);
    read_all();
  endtask

  task automatic rand_x();
    for (int i = 0; i < N; i++) tb_x[i] = 32'($urandom_range(32'(QL - 1), 0));
  endtask

  initial begin
    build_zetas();
    // pin the model with hand-known values
    check("zeta1", 64'(tb_zeta[1]), 64'd4808194);
    check("zeta2", 64'(tb_zeta[2]), 64'd3765607);
    check("zeta3", 64'(tb_zeta[3]), 64'd3761513);
    for (int i = 0; i < N; i++) tb_x[i] = (i == 0) ? 32'd5 : 32'd0;
    ref_ntt();
    for (int i = 0; i < N; i++) check("model_delta5", {32'd0, tb_y[i]}, 64'd5);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_read_data", {32'd0, read_data}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_en = 1'b1;

    // all-zero input
    for (int i = 0; i < N; i++) begin tb_x[i] = '0; tb_y[i] = '0; end
    run_and_read(1'b0, 1'b0);

    // delta of 5 spreads to every output
    for (int i = 0; i < N; i++) begin tb_x[i] = (i == 0) ? 32'd5 : 32'd0; tb_y[i] = 32'd5; end
    run_and_read(1'b0, 1'b0);

    // random inputs
    rand_x(); ref_ntt();
    run_and_read(1'b0, 1'b0);

    // load during COMPUTE ignored, start held through DONE gives no restart
    rand_x(); ref_ntt();
    run_and_read(1'b1, 1'b1);

    // reset mid-COMPUTE, then a clean reload and run
    rand_x();
    load_and_start(1'b0);
    wait_cyc(m_c + 40);
    rst_n = 1'b0;
    wait_cyc(m_c + 41);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_state", {62'd0, dbg_state}, 64'd0);
    @(posedge clk); #1;
    rand_x(); ref_ntt();
    run_and_read(1'b0, 1'b0);

`ifdef NTT_FWD_LOAD_REDUCE_EN
    for (int i = 0; i < N; i++) begin tb_x[i] = (i == 0) ? 32'd8380418 : 32'd0; tb_y[i] = 32'd1; end
    run_and_read(1'b0, 1'b0);
`endif

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) check("reads_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ntt_forward.md
# ntt_forward

Forward N=256 negacyclic Cooley-Tukey NTT engine over Z_Q, Q=8380417. It is the transmit-side counterpart of the inverse NTT pipeline: coefficients are loaded in natural order and transformed in place. The block produces bit-reversed-order NTT output that the inverse block consumes directly. It has no final scaling pass and completes in LOGN·N/(2·PARALLEL) compute cycles.

## Interface
- N, 256, transform size (power of two)
- WIDTH, 32, coefficient width
- Q, 8380417, modulus
- ADDR_WIDTH, 8, log2(N)
- REDUCTION_TYPE, 0, passed to mod_mult / butterfly (0=simple, 1=Barrett, 2=Montgomery)
- PARALLEL, 8, butterflies per cycle; power of two, must divide N/2
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low, single clock domain
- start  in  1  begin transform (sampled in IDLE only)
- done  out  1  transform complete, held until start deasserts
- busy  out  1  high in COMPUTE
- load_coeff  in  1  coefficient write enable (honoured in IDLE only)
- load_addr  in  ADDR_WIDTH  coefficient index
- load_data  in  WIDTH  coefficient value
- read_addr  in  ADDR_WIDTH  result index
- read_data  out  WIDTH  registered read result

## Operation
- FSM states: IDLE, COMPUTE, DONE.
  - IDLE→COMPUTE on start.
  - COMPUTE→DONE after the last butterfly group is written.
  - DONE→IDLE when start=0.
  - start while in COMPUTE is ignored.
- Storage: N-word in-place register array. It is not reset.
- Counters:
  - stage s runs 0..LOGN-1.
  - base k runs 0..N/2-PARALLEL in steps of PARALLEL.
  - At the last base, k wraps to 0 and s increments.
  - At the last base of the last stage, the FSM moves to DONE.
- Per lane i, butterfly index b = k+i.
  - len = N>>(s+1), so len runs 128, 64, …, 1.
  - group = b>>(LOGN-1-s); pos = b&(len-1).
  - addr0 = group·2·len+pos; addr1 = addr0+len.
  - Twiddle index = (1<<s)+group into fwd_twiddle_rom.
- fwd_twiddle_rom[j] = 1753^brv8(j) mod Q. Entry 0 is unused.
- Butterfly, computed combinationally from the array; results are written at the clock edge:
  - t = zeta·B mod Q.
  - A' = A+t, minus Q if ≥Q.
  - B' = A−t, plus Q if A<t.
- Arithmetic rules:
  - Operands are required to be <Q; all outputs are <Q.
  - The product is 2·WIDTH bits wide before reduction.
- Load: a write occurs only when state==IDLE and load_coeff=1.
- Read: read_data is updated every cycle from read_addr in any state. During COMPUTE it returns intermediate values.

## Timing
- Reset values: state=IDLE, done=0, busy=0, read_data=0, counters=0.
- done and busy are decoded from the state register; they carry no extra latency.
- start is asserted in cycle T:
  - busy=1 from T+1.
  - With P=8, compute occupies cycles T+1..T+128.
  - done=1 from T+129.
- load_coeff and start in the same IDLE cycle: the write lands at that edge, and COMPUTE uses the new value.
- read_data latency is 1 cycle.
- rst_n=0 mid-COMPUTE: the next edge returns the block to IDLE with counters cleared. Array contents are then undefined. A new load plus start must work normally.
- The DONE state persists while start stays high; no restart occurs until start has been low for at least one cycle.

## Configuration
- NTT_FWD_LOAD_REDUCE_EN
  - Defined: load_data is reduced mod Q before storage (full `%` Q on WIDTH bits), so any 32-bit input is legal.
  - Undefined: load_data is stored raw, and values ≥Q produce unspecified results.

## Structure
- Shared package ntt_pkg holds:
  - Q, N, LOGN, ZETA=1753
  - the state_t enum
  - the bit_reverse function
- Sub-module fwd_twiddle_rom: combinational N-entry ROM with an ADDR_WIDTH address. It is instantiated once per lane.
- Existing modules reused:
  - ntt_butterfly_forward, one per lane.
  - mod_mult, inside the butterfly.
- Stage and base counters live inline, not in ntt_control_parallel, because stage order and len are reversed relative to the inverse schedule.

## Test plan
- All-zero input, start → done at start+129 cycles; all 256 reads return 0.
- x[0]=5, others 0 → all 256 outputs equal 5.
- Random x<Q → outputs match the software reference NTT (Dilithium zetas, bit-reversed order); feeding the outputs to ntt_inverse returns the original x.
- rst_n low for 1 cycle at start+40 → busy=0 and done=0 on the next cycle; a reload followed by a fresh run gives correct results.
- load_coeff during COMPUTE (addr 3, data 77) is ignored, and a start pulse in DONE with start held gives no restart → results match the run without these events.
- With NTT_FWD_LOAD_REDUCE_EN defined: load 8380418 at addr 0 with the rest 0 → all outputs equal 1.
